// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding and default bit timing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/mux8to1.sv
// Eight-way single-bit selector: y carries din[sel].
module mux8to1 (
    input  logic [7:0] din,
    input  logic [2:0] sel,
    output logic       y
);

    assign y = din[sel];

endmodule

// File: rtl/uart_tx_seq.sv
// UART 8N1 transmitter: accepts one byte per frame and drives the serial line LSB-first.
// The FSM state is mirrored on dbg_state so that checkers can follow the frame phase.
module uart_tx_seq
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       holding;
    logic             bit_end;
    logic             accept;
    logic             data_bit;
    logic             tx_n;

    // Handshake: a byte transfers on a rising edge where tx_valid and tx_ready are
    // both 1; tx_ready is high only in IDLE, so tx_valid while busy is simply ignored.
    assign tx_ready  = (state == IDLE);
    assign busy      = ~tx_ready;
    assign accept    = tx_valid && tx_ready;
    assign bit_end   = (cnt == CNT_LAST);
    assign dbg_state = state;

    // Select with the upcoming index so the registered line changes on the boundary edge.
    mux8to1 u_bit_mux (
        .din (holding),
        .sel (idx_n),
        .y   (data_bit)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        case (state)
            IDLE:  if (tx_valid) state_n = START;
            START: if (bit_end) state_n = DATA;
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end
            end
            STOP:  if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Every state entry restarts both counters so nothing carries across frames.
        if (state_n != state) begin
            cnt_n = '0;
            idx_n = '0;
        end else if (state == IDLE || bit_end) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt + 1'b1;
        end

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_bit;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            holding <= 8'h00;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            tx      <= tx_n;
            tx_done <= (state == STOP) && (state_n == IDLE);
            if (accept) holding <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_seq.sv
// Self-checking bench for uart_tx_seq with a short bit time; expected line levels come
// from the 10-bit frame pattern {stop, data, start} stretched to CPB cycles per bit.
module tb_uart_tx_seq;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [1:0] dbg_state;

    int n_vectors;
    int n_miscompares;

    logic [0:0] exp_q[$];

    uart_tx_seq #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle();
        check("idle_tx", tx, 1'b1);
        check("idle_ready", tx_ready, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_done", tx_done, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle();
        end
    endtask

    // Called at a negedge with the DUT idle; offers d, then checks every frame cycle and
    // the tx_done cycle. keep_valid holds tx_valid/tx_data through the frame, inject
    // pulses a stray 0x3C mid-DATA, scramble randomises tx_data after the handshake.
    task automatic send_frame(input logic [7:0] d, input bit keep_valid,
                              input bit inject, input bit scramble);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        exp_q.delete();
        for (int b = 0; b < 10; b++)
            for (int c = 0; c < CPB; c++)
                exp_q.push_back(fr[b]);
        tx_valid = 1'b1;
        tx_data  = d;
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            if (!keep_valid) tx_valid = 1'b0;
            if (scramble && !keep_valid) tx_data = 8'($urandom);
            if (inject && k == 16) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end
            if (inject && k == 17) tx_valid = 1'b0;
            check("frame_tx", tx, exp_q.pop_front());
            check("frame_ready", tx_ready, 1'b0);
            check("frame_busy", busy, 1'b1);
            check("frame_done", tx_done, 1'b0);
        end
        @(negedge clk);
        check("end_tx", tx, 1'b1);
        check("end_done", tx_done, 1'b1);
        check("end_ready", tx_ready, 1'b1);
        check("end_busy", busy, 1'b0);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_state", dbg_state, 2'd0);

        // Handshake on the very first edge after reset release, 0xA5 frame.
        rst = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        idle_cycles(3);

        // Back-to-back with tx_valid held: one idle-high cycle between frames.
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        tx_valid = 1'b0;
        idle_cycles(2);

        // Stray request while busy is ignored.
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);

        // Input data churn after the handshake has no effect.
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        idle_cycles(2);

        // Reset in the middle of data bit 3 of 0x55.
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        check("pre_abort_tx", tx, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_ready", tx_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", tx_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_hold_done", tx_done, 1'b0);
            check("abort_hold_tx", tx, 1'b1);
        end
        rst = 1'b0;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);

        // Randomised traffic: random bytes, gaps and input behaviour.
        for (int n = 0; n < 12; n++) begin
            int mode;
            int gap;
            logic [7:0] d;
            d    = 8'($urandom);
            mode = $urandom_range(0, 2);
            gap  = $urandom_range(0, 3);
            idle_cycles(gap);
            send_frame(d, mode == 0, mode == 1, mode == 2);
            tx_valid = 1'b0;
        end
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_seq.md
UART_TX_SEQ -- requirements
Module: uart_tx_seq

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (legal range 2..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 tx_data  input  8  byte to transmit, sampled only on an accepted handshake.
REQ-005 tx_valid  input  1  producer has a byte on tx_data.
REQ-006 tx_ready  output  1  block can accept a byte this cycle.
REQ-007 tx  output  1  serial line, registered, idle level high.
REQ-008 busy  output  1  frame in progress (any state other than IDLE).
REQ-009 tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 States SHALL be IDLE, START, DATA, STOP; frame = 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
REQ-011 tx_ready SHALL equal 1 exactly when state is IDLE; busy SHALL equal its inverse.
REQ-012 Handshake occurs on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL be latched into a holding register on that edge and the state SHALL move to START.
REQ-013 tx_valid while busy SHALL be ignored; no byte is latched or lost-state corrupted.
REQ-014 Changes on tx_data after the handshake SHALL have no effect on the frame in progress.
REQ-015 A baud counter SHALL hold each bit for exactly CLKS_PER_BIT cycles; tx SHALL change only at bit boundaries.
REQ-016 tx SHALL go low on the edge that enters START, i.e. one cycle after the handshake cycle.
REQ-017 A 3-bit index SHALL step 0..7 through DATA; tx SHALL carry holding[index]; leaving DATA occurs after index 7 completes.
REQ-018 The full frame SHALL occupy exactly 10*CLKS_PER_BIT cycles from entry to START to entry to IDLE.
REQ-019 On the edge leaving STOP, state SHALL be IDLE, tx SHALL stay 1, and tx_done SHALL be 1 for exactly that one IDLE cycle.
REQ-020 Back-to-back: with tx_valid held high, the next byte SHALL be accepted in the first IDLE cycle (same cycle as tx_done), giving one idle-high cycle between stop and next start.
REQ-021 Baud counter and index SHALL clear on every state entry; no counter wrap SHALL leak between frames.

Reset
REQ-022 While rst=1: state IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, holding register 0x00, counters 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with outputs per REQ-022; no tx_done pulse SHALL follow.
REQ-024 First handshake after reset release SHALL be possible on the first rising edge with rst=0.

Structure
REQ-025 Package uart_pkg SHALL hold the state encoding (2-bit, IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT constant.
REQ-026 Data-bit selection SHALL instantiate the team's existing mux8to1 as the single sub-module, holding register on din and index-derived select on sel, wired so the line order is LSB-first.
REQ-027 Baud counter width SHALL be derived from CLKS_PER_BIT (ceil log2), not hard-coded.

Verification (CLKS_PER_BIT=4)
REQ-028 Send 0xA5 -> tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; tx_done one cycle, 40 cycles after START entry.
REQ-029 Hold tx_valid with 0x00 then 0xFF -> second start bit exactly 1 idle cycle after first tx_done; data bits 0x00 all low, 0xFF all high.
REQ-030 Pulse tx_valid with 0x3C during DATA of a 0x81 frame -> ignored; only 0x81 appears, tx_ready stays 0 until IDLE.
REQ-031 Assert rst during data bit 3 of 0x55 -> tx=1, tx_ready=1, busy=0 immediately, no tx_done; next 0x0F then transmits correctly.
REQ-032 Change tx_data every cycle after handshake of 0xC3 -> line still carries 0xC3 LSB-first (1,1,0,0,0,0,1,1).
